// File: rtl/mem_responder.sv
// Single-port 256x8 register-file responder driven by a req/ack handshake.
// Latency: ack in cycle WAIT_CYCLES+2, counting the first IDLE cycle with req high as cycle 1.
// Backpressure: one transaction in flight; req/we/addr/wdata are ignored until the FSM is back in IDLE.
//
// Ports:
//   clk, rst         sole clock, synchronous active-high reset
//   req, we          request (held until ack) and write select
//   addr, wdata      access address and write data, latched in IDLE
//   rdata            registered read data, zeroed by an out-of-range access
//   ack, err         one-cycle completion pulse, error flag valid with ack
//   busy             high in WAIT and ACK
//   txn_count        wrapping count of completed transactions
module mem_responder #(
   parameter int         WAIT_CYCLES = 1,
   parameter logic [7:0] ADDR_MAX    = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       ack,
   output logic       err,
   output logic       busy,
   output logic [7:0] txn_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [8:0] ADDR_LIM  = {1'b0, ADDR_MAX};

   state_t     state;
   logic [3:0] wait_cnt;
   logic       we_q;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] mem [256];

   // Access actually committed on this edge. With no wait states the
   // commit edge is the one leaving IDLE, so the live inputs are used
   // directly; otherwise the values latched in IDLE are used.
   logic       commit;
   logic       c_we;
   logic [7:0] c_addr;
   logic [7:0] c_wdata;
   logic       c_oor;

   always_comb begin
      commit  = 1'b0;
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      case (state)
         IDLE: begin
            if (req && NO_WAIT) begin
               commit  = 1'b1;
               c_we    = we;
               c_addr  = addr;
               c_wdata = wdata;
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd1) begin
               commit = 1'b1;
            end
         end
         default: begin
         end
      endcase
      // Widened compare keeps the check meaningful when ADDR_MAX is 8'hFF.
      c_oor = ({1'b0, c_addr} > ADDR_LIM);
   end

   // Storage is deliberately not reset; reset only blocks a pending write.
   always_ff @(posedge clk) begin
      if (!rst && commit && c_we && !c_oor) begin
         mem[c_addr] <= c_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= 4'd0;
         we_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         ack       <= 1'b0;
         err       <= 1'b0;
         busy      <= 1'b0;
         rdata     <= 8'h00;
         txn_count <= 8'h00;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  we_q     <= we;
                  addr_q   <= addr;
                  wdata_q  <= wdata;
                  wait_cnt <= WAIT_INIT;
                  busy     <= 1'b1;
                  state    <= NO_WAIT ? ACK : WAIT;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state <= ACK;
               end
            end
            ACK: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase

         if (commit) begin
            ack       <= 1'b1;
            txn_count <= txn_count + 8'd1;
            if (c_oor) begin
               err   <= 1'b1;
               rdata <= 8'h00;
            end else if (!c_we) begin
               rdata <= mem[c_addr];
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances cover WAIT_CYCLES 1/0/3 and a reduced ADDR_MAX.
// Latency and handshake timing are checked on every transaction.
// Expected results are queued when a request is driven and popped when ack appears.
module tb_mem_responder;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // index 0: WAIT_CYCLES=1, ADDR_MAX=7F; index 1: WAIT_CYCLES=0; index 2: WAIT_CYCLES=3
   logic       rst_s   [3];
   logic       req_s   [3];
   logic       we_s    [3];
   logic [7:0] addr_s  [3];
   logic [7:0] wdata_s [3];
   logic [7:0] rdata_s [3];
   logic       ack_s   [3];
   logic       err_s   [3];
   logic       busy_s  [3];
   logic [7:0] txn_s   [3];

   int         wc   [3] = '{1, 0, 3};
   logic [7:0] amax [3] = '{8'h7F, 8'hFF, 8'hFF};

   mem_responder #(.WAIT_CYCLES(1), .ADDR_MAX(8'h7F)) u_w1 (
      .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
      .wdata(wdata_s[0]), .rdata(rdata_s[0]), .ack(ack_s[0]), .err(err_s[0]),
      .busy(busy_s[0]), .txn_count(txn_s[0]));

   mem_responder #(.WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
      .wdata(wdata_s[1]), .rdata(rdata_s[1]), .ack(ack_s[1]), .err(err_s[1]),
      .busy(busy_s[1]), .txn_count(txn_s[1]));

   mem_responder #(.WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
      .wdata(wdata_s[2]), .rdata(rdata_s[2]), .ack(ack_s[2]), .err(err_s[2]),
      .busy(busy_s[2]), .txn_count(txn_s[2]));

   typedef struct {
      logic [7:0] rd;
      logic       er;
   } exp_t;

   typedef struct {
      int         d;
      logic       w;
      logic [7:0] a;
      logic [7:0] wd;
      logic [7:0] rd;
      logic       er;
   } vec_t;

   exp_t       sb [$];
   vec_t       tbl [13];
   logic [7:0] mem_m   [3][256];
   logic [7:0] exp_rd  [3];
   logic [7:0] exp_cnt [3];
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic pulse_rst(input int i);
      @(posedge clk); #1;
      rst_s[i] = 1'b1;
      req_s[i] = 1'b0;
      @(posedge clk); #1;
      rst_s[i]   = 1'b0;
      exp_rd[i]  = 8'h00;
      exp_cnt[i] = 8'h00;
   endtask

   // Runs one transaction. mut scrambles we/addr/wdata once the request has
   // been taken, which must not affect the committed access.
   task automatic do_txn(input int i, input logic w, input logic [7:0] a, input logic [7:0] d,
                         input bit mut, input bit use_tbl, input logic [7:0] trd, input logic terr);
      exp_t m;
      exp_t e;
      int   n;
      bit   got;
      bit   bad;
      if ({1'b0, a} > {1'b0, amax[i]}) begin
         m.er = 1'b1;
         m.rd = 8'h00;
      end else if (w) begin
         mem_m[i][a] = d;
         m.er = 1'b0;
         m.rd = exp_rd[i];
      end else begin
         m.er = 1'b0;
         m.rd = mem_m[i][a];
      end
      exp_rd[i]  = m.rd;
      exp_cnt[i] = exp_cnt[i] + 8'd1;
      if (use_tbl) begin
         e.rd = trd;
         e.er = terr;
         sb.push_back(e);
      end else begin
         sb.push_back(m);
      end

      @(posedge clk); #1;
      req_s[i]   = 1'b1;
      we_s[i]    = w;
      addr_s[i]  = a;
      wdata_s[i] = d;
      n   = 0;
      got = 1'b0;
      bad = 1'b0;
      while (!got && n < 20) begin
         n++;
         @(negedge clk);
         if (busy_s[i] !== (n > 1)) bad = 1'b1;
         if (ack_s[i] === 1'b1) begin
            got = 1'b1;
         end else begin
            if (err_s[i] !== 1'b0) bad = 1'b1;
            @(posedge clk); #1;
            if (n == 1 && mut) begin
               addr_s[i]  = a ^ 8'h01;
               wdata_s[i] = ~d;
               we_s[i]    = ~w;
            end
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL ack_timeout dut=%0d actual=no_ack expected=ack_in_%0d_cycles", i, wc[i] + 2);
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         e = sb.pop_front();
         chk("latency", n, wc[i] + 2);
         chk("handshake_busy_err", {31'd0, bad}, 32'd0);
         chk("rdata", {24'd0, rdata_s[i]}, {24'd0, e.rd});
         chk("err", {31'd0, err_s[i]}, {31'd0, e.er});
         chk("txn_count", {24'd0, txn_s[i]}, {24'd0, exp_cnt[i]});
      end
      @(posedge clk); #1;
      req_s[i] = 1'b0;
      @(negedge clk);
      chk("idle_after_ack", {29'd0, ack_s[i], err_s[i], busy_s[i]}, 32'd0);
   endtask

   task automatic txn(input int i, input logic w, input logic [7:0] a, input logic [7:0] d);
      do_txn(i, w, a, d, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   initial begin
      tbl[0]  = '{0, 1'b1, 8'h10, 8'hA5, 8'h00, 1'b0};
      tbl[1]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
      tbl[2]  = '{0, 1'b1, 8'h80, 8'h55, 8'h00, 1'b1};
      tbl[3]  = '{0, 1'b0, 8'h80, 8'h00, 8'h00, 1'b1};
      tbl[4]  = '{0, 1'b0, 8'h10, 8'h00, 8'hA5, 1'b0};
      tbl[5]  = '{0, 1'b1, 8'h7F, 8'hC3, 8'hA5, 1'b0};
      tbl[6]  = '{0, 1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0};
      tbl[7]  = '{0, 1'b1, 8'h00, 8'h5A, 8'hC3, 1'b0};
      tbl[8]  = '{0, 1'b0, 8'h00, 8'h00, 8'h5A, 1'b0};
      tbl[9]  = '{1, 1'b1, 8'h01, 8'h11, 8'h00, 1'b0};
      tbl[10] = '{1, 1'b0, 8'h01, 8'h00, 8'h11, 1'b0};
      tbl[11] = '{2, 1'b1, 8'h20, 8'h11, 8'h00, 1'b0};
      tbl[12] = '{2, 1'b0, 8'h20, 8'h00, 8'h11, 1'b0};

      for (int i = 0; i < 3; i++) begin
         rst_s[i]   = 1'b1;
         req_s[i]   = 1'b0;
         we_s[i]    = 1'b0;
         addr_s[i]  = 8'h00;
         wdata_s[i] = 8'h00;
         exp_rd[i]  = 8'h00;
         exp_cnt[i] = 8'h00;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk("reset_outputs", {21'd0, ack_s[i], err_s[i], busy_s[i], rdata_s[i], txn_s[i]}, 32'd0);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) rst_s[i] = 1'b0;

      // Table: write/read, out-of-range, boundary address on each instance.
      for (int k = 0; k < 13; k++) begin
         do_txn(tbl[k].d, tbl[k].w, tbl[k].a, tbl[k].wd, 1'b0, 1'b1, tbl[k].rd, tbl[k].er);
      end

      // Inputs changed during WAIT must not reach the committed access.
      txn(0, 1'b1, 8'h31, 8'h44);
      do_txn(0, 1'b1, 8'h30, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0);
      txn(0, 1'b0, 8'h30, 8'h00);
      txn(0, 1'b0, 8'h31, 8'h00);

      // Back-to-back with no wait states: ack and busy on every second cycle.
      pulse_rst(1);
      @(posedge clk); #1;
      req_s[1]  = 1'b1;
      we_s[1]   = 1'b0;
      addr_s[1] = 8'h01;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         chk("b2b_ack", {31'd0, ack_s[1]}, {31'd0, (c % 2 == 0)});
         chk("b2b_busy", {31'd0, busy_s[1]}, {31'd0, (c % 2 == 0)});
      end
      chk("b2b_txn_count", {24'd0, txn_s[1]}, 32'd4);
      chk("b2b_rdata", {24'd0, rdata_s[1]}, 32'h11);
      @(posedge clk); #1;
      req_s[1] = 1'b0;
      exp_cnt[1] = 8'd4;
      exp_rd[1]  = 8'h11;

      // Reset on the commit edge abandons the write.
      @(posedge clk); #1;
      req_s[2]   = 1'b1;
      we_s[2]    = 1'b1;
      addr_s[2]  = 8'h20;
      wdata_s[2] = 8'h3C;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_s[2] = 1'b1;
      @(negedge clk);
      chk("pre_commit_no_ack", {31'd0, ack_s[2]}, 32'd0);
      @(posedge clk); #1;
      rst_s[2] = 1'b0;
      req_s[2] = 1'b0;
      @(negedge clk);
      chk("rst_commit_outputs", {21'd0, ack_s[2], err_s[2], busy_s[2], rdata_s[2], txn_s[2]}, 32'd0);
      exp_rd[2]  = 8'h00;
      exp_cnt[2] = 8'h00;
      repeat (3) begin
         @(negedge clk);
         chk("rst_commit_no_late_ack", {31'd0, ack_s[2]}, 32'd0);
      end
      txn(2, 1'b0, 8'h20, 8'h00);

      // txn_count wrap.
      pulse_rst(0);
      for (int k = 0; k < 254; k++) txn(0, 1'b0, 8'h10, 8'h00);
      chk("wrap_preload", {24'd0, txn_s[0]}, 32'hFE);
      txn(0, 1'b0, 8'h10, 8'h00);
      chk("wrap_ff", {24'd0, txn_s[0]}, 32'hFF);
      txn(0, 1'b0, 8'h7F, 8'h00);
      chk("wrap_00", {24'd0, txn_s[0]}, 32'h00);
      txn(0, 1'b0, 8'h10, 8'h00);
      chk("wrap_01", {24'd0, txn_s[0]}, 32'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
